// File: rtl/step_accumulator.sv
// step_accumulator: iterated signed step up/down with wrap or saturate, registered flags and busy/done handshake
module step_accumulator #(
  parameter int BITS = 4,
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sel,
  input  logic                mode,
  input  logic                sat,
  input  logic [BITS-1:0]     A,
  input  logic [BITS-1:0]     B,
  input  logic [BITS-1:0]     step,
  input  logic [CNT_BITS-1:0] reps,
  output logic [BITS-1:0]     result,
  output logic                N,
  output logic                Z,
  output logic                V,
  output logic                Co,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [BITS-1:0] SMIN = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] SMAX = ~SMIN;
  state_t state, state_n;
  logic [BITS-1:0] acc, step_r, opnd, sum, nxt, opv;
  logic [CNT_BITS-1:0] rem;
  logic mode_r, sat_r, vs, co_w, ovf, accept;
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  // single adder; decrement is acc + ~step + 1 so Co=1 means no borrow
  always_comb begin
    accept = start && state != S_RUN;
    opv = sel ? B : A;
    opnd = mode_r ? ~step_r : step_r;
    {co_w, sum} = {1'b0, acc} + {1'b0, opnd} + (BITS+1)'(mode_r);
    ovf = (acc[BITS-1] == opnd[BITS-1]) && (sum[BITS-1] != acc[BITS-1]);
    nxt = (sat_r && ovf) ? (acc[BITS-1] ? SMIN : SMAX) : sum;
    state_n = accept ? (reps == '0 ? S_DONE : S_RUN)
            : state == S_RUN ? (rem == CNT_BITS'(1) ? S_DONE : S_RUN)
            : S_IDLE;
  end
  // state, datapath and flag registers; flags only move on R=0 accept or final iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc <= '0;
      step_r <= '0;
      rem <= '0;
      mode_r <= 1'b0;
      sat_r <= 1'b0;
      vs <= 1'b0;
      result <= '0;
      N <= 1'b0;
      Z <= 1'b0;
      V <= 1'b0;
      Co <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        acc <= opv;
        step_r <= step;
        mode_r <= mode;
        sat_r <= sat;
        rem <= reps;
        vs <= 1'b0;
        if (reps == '0) begin
          result <= opv;
          N <= opv[BITS-1];
          Z <= opv == '0;
          V <= 1'b0;
          Co <= 1'b0;
        end
      end else if (state == S_RUN) begin
        acc <= nxt;
        vs <= vs | ovf;
        rem <= rem - CNT_BITS'(1);
        if (rem == CNT_BITS'(1)) begin
          result <= nxt;
          N <= nxt[BITS-1];
          Z <= nxt == '0;
          V <= vs | ovf;
          Co <= co_w;
        end
      end
    end
  end
endmodule

// File: tb/tb_step_accumulator.sv
// tb_step_accumulator: directed and randomized checks against an integer reference model
module tb_step_accumulator;
  logic clk = 0, rst = 1, start = 0, sel = 0, mode = 0, sat = 0;
  logic [3:0] A = 0, B = 0, step = 0, reps = 0;
  logic [3:0] result;
  logic N, Z, V, Co, busy, done;
  int total = 0, bad = 0;

  step_accumulator #(.BITS(4), .CNT_BITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .mode(mode), .sat(sat),
    .A(A), .B(B), .step(step), .reps(reps), .result(result),
    .N(N), .Z(Z), .V(V), .Co(Co), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic i_sel, input logic i_mode, input logic i_sat,
                       input logic [3:0] i_a, input logic [3:0] i_b,
                       input logic [3:0] i_step, input logic [3:0] i_reps);
    int acc, s, t, v_e, co_e, busy_n, cyc;
    logic o;
    acc = i_sel ? int'($signed(i_b)) : int'($signed(i_a));
    s = int'($signed(i_step));
    v_e = 0;
    co_e = 0;
    for (int i = 0; i < int'(i_reps); i++) begin
      t = i_mode ? acc - s : acc + s;
      co_e = i_mode ? int'((acc & 15) >= (s & 15)) : int'((acc & 15) + (s & 15) > 15);
      o = t > 7 || t < -8;
      v_e = v_e | int'(o);
      acc = (o && i_sat) ? (t > 7 ? 7 : -8) : ((t + 8) & 15) - 8;
    end
    sel = i_sel; mode = i_mode; sat = i_sat; A = i_a; B = i_b; step = i_step; reps = i_reps;
    start = 1;
    tick();
    start = 0;
    busy_n = 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      busy_n += int'(busy);
      A = 4'($urandom); B = 4'($urandom); step = 4'($urandom); reps = 4'($urandom);
      sel = 1'($urandom); mode = 1'($urandom); sat = 1'($urandom);
      start = busy && 1'($urandom);
      tick();
      cyc++;
    end
    start = 0;
    chk("done_seen", done, 1);
    chk("latency", cyc, i_reps);
    chk("busy_cycles", busy_n, i_reps);
    chk("result", result, acc & 15);
    chk("N", N, acc < 0);
    chk("Z", Z, acc == 0);
    chk("V", V, v_e);
    chk("Co", Co, co_e);
  endtask

  initial begin
    int seen;
    tick();
    tick();
    chk("rst_result", result, 0);
    chk("rst_flags", {N, Z, V, Co, busy, done}, 0);
    rst = 0;
    tick();
    do_op(0, 1, 0, 4'd3, 4'd0, 4'd1, 4'd1);
    chk("t1_res", result, 4'b0010);
    chk("t1_flags", {N, Z, V, Co}, 4'b0001);
    tick();
    chk("t1_pulse", done, 0);
    do_op(0, 1, 0, 4'b1000, 4'd0, 4'd1, 4'd1);
    chk("t2w_res", {result, N, V, Co}, {4'b0111, 3'b011});
    tick();
    do_op(0, 1, 1, 4'b1000, 4'd0, 4'd1, 4'd1);
    chk("t2s_res", {result, N, V}, {4'b1000, 2'b11});
    tick();
    do_op(1, 0, 0, 4'd0, 4'd5, 4'd2, 4'd3);
    chk("t3w_res", {result, V, Co, N}, {4'b1011, 3'b101});
    tick();
    do_op(1, 0, 1, 4'd0, 4'd5, 4'd2, 4'd3);
    chk("t3s_res", {result, V}, {4'b0111, 1'b1});
    do_op(0, 1, 0, 4'd1, 4'd0, 4'd1, 4'd1);
    chk("t6_res", {result, Z, Co, V}, {4'b0000, 3'b110});
    tick();
    do_op(0, 0, 0, 4'd0, 4'd9, 4'd7, 4'd0);
    chk("t4_res", {result, Z, V, Co}, {4'b0000, 3'b100});
    tick();
    do_op(0, 0, 0, 4'd2, 4'd0, 4'd1, 4'd5);
    chk("t5_res", result, 4'd7);
    tick();
    sel = 0; mode = 0; sat = 0; A = 4'd2; step = 4'd1; reps = 4'd5;
    start = 1;
    tick();
    start = 1; A = 4'd6;
    tick();
    start = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t5_rst_res", result, 0);
    chk("t5_rst_flags", {N, Z, V, Co, busy, done}, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      seen |= int'(done) | int'(busy);
      tick();
    end
    chk("t5_no_done", seen, 0);
    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom_range(0, 15)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
